// File: rtl/tmds_encoder_hdmi.sv
// HDMI TMDS channel encoder: DVI 8b/10b video, control symbols, video guard
// bands, TERC4 data-island symbols and island guard bands. Includes a 1- or
// 2-stage pipeline and a sticky guard-band sequencing checker.
module tmds_encoder_hdmi #(
  parameter int CHANNEL  = 0,
  parameter int PIPELINE = 1
) (
  input  logic       clk_pix,
  input  logic       rst_n,
  input  logic [2:0] mode,
  input  logic [7:0] data_in,
  input  logic [1:0] ctrl_in,
  input  logic [3:0] aux_in,
  output logic [9:0] tmds,
  output logic [4:0] bias,
  output logic       seq_err
);

  localparam logic [2:0] MODE_CTRL      = 3'd0;
  localparam logic [2:0] MODE_VIDEO     = 3'd1;
  localparam logic [2:0] MODE_VIDEO_GB  = 3'd2;
  localparam logic [2:0] MODE_ISLAND    = 3'd3;
  localparam logic [2:0] MODE_ISLAND_GB = 3'd4;

  localparam logic [9:0] SYM_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] SYM_GB_A    = 10'b1011001100;
  localparam logic [9:0] SYM_GB_B    = 10'b0100110011;

  // TERC4 nibble-to-symbol lookup.
  function automatic logic [9:0] terc4(input logic [3:0] n);
    logic [9:0] s;
    case (n)
      4'h0: s = 10'b1010011100;
      4'h1: s = 10'b1001100011;
      4'h2: s = 10'b1011100100;
      4'h3: s = 10'b1011100010;
      4'h4: s = 10'b0101110001;
      4'h5: s = 10'b0100011110;
      4'h6: s = 10'b0110001110;
      4'h7: s = 10'b0100111100;
      4'h8: s = 10'b1011001100;
      4'h9: s = 10'b0100111001;
      4'hA: s = 10'b0110011100;
      4'hB: s = 10'b1011000110;
      4'hC: s = 10'b1010001110;
      4'hD: s = 10'b1001110001;
      4'hE: s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  // Control-period symbol lookup.
  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00: s = 10'b1101010100;
      2'b01: s = 10'b0010101011;
      2'b10: s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------
  // Stage 0: input decode, transition-minimised qm and its balance
  // ---------------------------------------------------------------------
  logic [2:0] mode_norm;
  logic [3:0] n1;
  logic       use_xnor;
  logic [8:0] qm_next;
  logic [3:0] ones;
  logic [4:0] balance_next;
  logic [9:0] fixed_next;

  // Unused mode encodings fall back to CTRL so they never drive video state.
  assign mode_norm = (mode > MODE_ISLAND_GB) ? MODE_CTRL : mode;

  // XOR/XNOR chain selection and disparity of the resulting 8 bits.
  always_comb begin
    logic acc;
    n1 = 4'd0;
    for (int i = 0; i < 8; i++) n1 = n1 + 4'(data_in[i]);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !data_in[0]);
    acc = data_in[0];
    qm_next = 9'd0;
    qm_next[0] = acc;
    for (int i = 1; i < 8; i++) begin
      acc = use_xnor ? ~(acc ^ data_in[i]) : (acc ^ data_in[i]);
      qm_next[i] = acc;
    end
    qm_next[8] = !use_xnor;
    ones = 4'd0;
    for (int i = 0; i < 8; i++) ones = ones + 4'(qm_next[i]);
    balance_next = {ones, 1'b0} - 5'd8;
  end

  // Symbol for every non-VIDEO mode, chosen from ctrl/aux and the channel.
  always_comb begin
    fixed_next = SYM_CTRL_00;
    case (mode_norm)
      MODE_VIDEO_GB:  fixed_next = (CHANNEL == 1) ? SYM_GB_B : SYM_GB_A;
      MODE_ISLAND:    fixed_next = terc4(aux_in);
      MODE_ISLAND_GB: fixed_next = (CHANNEL == 0) ? terc4({2'b11, aux_in[1:0]}) : SYM_GB_B;
      default:        fixed_next = ctrl_sym(ctrl_in);
    endcase
  end

  // ---------------------------------------------------------------------
  // Optional stage-1 register between decode and DC balancing
  // ---------------------------------------------------------------------
  logic [2:0] s1_mode;
  logic [8:0] s1_qm;
  logic [4:0] s1_balance;
  logic [9:0] s1_fixed;

  generate
    if (PIPELINE == 1) begin : g_pipe1
      assign s1_mode    = mode_norm;
      assign s1_qm      = qm_next;
      assign s1_balance = balance_next;
      assign s1_fixed   = fixed_next;
    end else if (PIPELINE == 2) begin : g_pipe2
      logic [2:0] mode_reg;
      logic [8:0] qm_reg;
      logic [4:0] balance_reg;
      logic [9:0] fixed_reg;

      // Stage 1 holds the decoded symbol; reset loads an idle CTRL 00 entry.
      always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
          mode_reg    <= MODE_CTRL;
          qm_reg      <= 9'd0;
          balance_reg <= 5'd0;
          fixed_reg   <= SYM_CTRL_00;
        end else begin
          mode_reg    <= mode_norm;
          qm_reg      <= qm_next;
          balance_reg <= balance_next;
          fixed_reg   <= fixed_next;
        end
      end

      assign s1_mode    = mode_reg;
      assign s1_qm      = qm_reg;
      assign s1_balance = balance_reg;
      assign s1_fixed   = fixed_reg;
    end else begin : g_bad_pipeline
      $error("tmds_encoder_hdmi: PIPELINE must be 1 or 2");
    end
  endgenerate

  generate
    if (CHANNEL < 0 || CHANNEL > 2) begin : g_bad_channel
      $error("tmds_encoder_hdmi: CHANNEL must be 0, 1 or 2");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Final stage: DC balancing with running disparity, plus the checker
  // ---------------------------------------------------------------------
  logic [9:0] tmds_reg, tmds_next;
  logic [4:0] bias_reg, bias_next;
  logic       seq_err_reg, seq_err_next;
  logic [2:0] prev_mode_reg;
  logic [1:0] gb_cnt_reg, gb_cnt_next;
  logic       trail_reg, trail_next;

  // Running-disparity selection; any non-VIDEO symbol forces bias back to 0.
  always_comb begin
    tmds_next = s1_fixed;
    bias_next = 5'd0;
    if (s1_mode == MODE_VIDEO) begin
      if ((bias_reg == 5'd0) || (s1_balance == 5'd0)) begin
        tmds_next = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
        bias_next = s1_qm[8] ? (bias_reg + s1_balance) : (bias_reg - s1_balance);
      end else if (bias_reg[4] == s1_balance[4]) begin
        tmds_next = {1'b1, s1_qm[8], ~s1_qm[7:0]};
        bias_next = bias_reg + {3'b000, s1_qm[8], 1'b0} - s1_balance;
      end else begin
        tmds_next = {1'b0, s1_qm[8], s1_qm[7:0]};
        bias_next = bias_reg - {3'b000, ~s1_qm[8], 1'b0} + s1_balance;
      end
    end
  end

  // Guard-band run tracking and violation detection against the previous mode.
  always_comb begin
    logic is_gb;
    logic viol;
    is_gb = (s1_mode == MODE_VIDEO_GB) || (s1_mode == MODE_ISLAND_GB);
    if (!is_gb)                       gb_cnt_next = 2'd0;
    else if (s1_mode != prev_mode_reg) gb_cnt_next = 2'd1;
    else if (gb_cnt_reg == 2'd3)       gb_cnt_next = 2'd3;
    else                               gb_cnt_next = gb_cnt_reg + 2'd1;

    // An island guard run that directly follows ISLAND is a trailing run.
    trail_next = 1'b0;
    if (s1_mode == MODE_ISLAND_GB) begin
      if (prev_mode_reg == MODE_ISLAND)         trail_next = 1'b1;
      else if (prev_mode_reg == MODE_ISLAND_GB) trail_next = trail_reg;
    end

    viol = 1'b0;
    if (s1_mode == MODE_VIDEO) begin
      if ((prev_mode_reg != MODE_VIDEO) && (prev_mode_reg != MODE_VIDEO_GB)) viol = 1'b1;
      if ((prev_mode_reg == MODE_VIDEO_GB) && (gb_cnt_reg != 2'd2))          viol = 1'b1;
    end
    if (s1_mode == MODE_ISLAND) begin
      if ((prev_mode_reg != MODE_ISLAND) && (prev_mode_reg != MODE_ISLAND_GB)) viol = 1'b1;
      if ((prev_mode_reg == MODE_ISLAND_GB) && !trail_reg && (gb_cnt_reg != 2'd2)) viol = 1'b1;
    end
    seq_err_next = seq_err_reg | viol;
  end

  // Output registers and checker state; reset discards everything in flight.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      tmds_reg      <= SYM_CTRL_00;
      bias_reg      <= 5'd0;
      seq_err_reg   <= 1'b0;
      prev_mode_reg <= MODE_CTRL;
      gb_cnt_reg    <= 2'd0;
      trail_reg     <= 1'b0;
    end else begin
      tmds_reg      <= tmds_next;
      bias_reg      <= bias_next;
      seq_err_reg   <= seq_err_next;
      prev_mode_reg <= s1_mode;
      gb_cnt_reg    <= gb_cnt_next;
      trail_reg     <= trail_next;
    end
  end

  assign tmds    = tmds_reg;
  assign bias    = bias_reg;
  assign seq_err = seq_err_reg;

endmodule
